poly_tone_player: RTL and testbench
===================================

// Module: poly_tone_player
// PURPOSE
//  N-channel square-wave note player with beat-quantised record/playback memory. Sits between the key
//  encoder and the audio Pmod pins; replaces the fixed two-channel player. Live key codes sound
//  directly when idle or recording. Playback sources the channels from the beat-indexed note memory.
// PARAMETERS
//  N_CH      2           number of tone channels
//  DEPTH     512         note-memory depth in beats; AW = $clog2(DEPTH)
//  CLK_HZ    100000000   clk frequency; used for the half-period table
//  BEAT_BASE 3125000     clk cycles per beat unit; beat period = BEAT_BASE*{4,6,7,8}[speed]
// PORTS
//  clk        in   1        system clock
//  reset      in   1        asynchronous, active-low reset
//  key_code   in   6*N_CH   live note per channel; 0 = rest, 1..48 = C4..B7, >48 treated as rest
//  mode_rec   in   1        level; selects record on start
//  mode_play  in   1        level; selects playback on start
//  start      in   1        1-cycle pulse; begins the selected operation
//  stop       in   1        1-cycle pulse; aborts REC/PLAY
//  speed      in   2        tempo select, sampled at each beat boundary
//  tone_out   out  N_CH     square wave per channel
//  beat_tick  out  1        1-cycle pulse at each beat boundary
//  beat_num   out  AW       current memory address (beat index)
//  rec_len    out  AW+1     beats held in memory (0..DEPTH)
//  state      out  2        00 IDLE, 01 REC, 10 PLAY
// BEHAVIOUR
//  Reset values: tone_out=0, beat_tick=0, beat_num=0, rec_len=0, state=IDLE, memory contents undefined.
//  Beat timer:
//   - Free-running in IDLE. Restarted to 0 on the cycle a start is accepted.
//   - beat_tick fires when the count reaches period-1.
//  FSM transitions:
//   - IDLE -> REC on start & mode_rec & !mode_play. Sets beat_num=0, rec_len=0.
//   - IDLE -> PLAY on start & mode_play & !mode_rec & rec_len!=0. Sets beat_num=0.
//   - start with both or neither mode bit, or with rec_len==0 for play, is ignored.
//   - start outside IDLE is ignored.
//   - stop in REC/PLAY -> IDLE next cycle. stop in the same cycle as start: stop wins, state stays IDLE.
//  REC:
//   - Each beat_tick writes key_code to mem[beat_num], then increments beat_num and rec_len.
//   - The write at beat_num==DEPTH-1 sets rec_len=DEPTH and returns to IDLE.
//   - stop keeps the beats written so far.
//  PLAY:
//   - Synchronous memory read with 1-cycle latency. The mem[0] note sounds 2 cycles after start accept.
//   - At each beat_tick beat_num advances; the new note reaches the channels 2 cycles later.
//   - The beat_tick at beat_num==rec_len-1 ends playback (see CONFIGURATION).
//  Tone generation, per channel:
//   - half = HALF_PERIOD[code] cycles; tone_out toggles every half cycles.
//   - A code change restarts the channel counter and forces tone_out low. Code 0 holds it low.
//   - Source: PLAY uses the played notes; IDLE and REC use live key_code.
//   - Leaving PLAY forces all channels to rest for 1 cycle, then they follow live input.
//  Arithmetic:
//   - HALF_PERIOD = CLK_HZ/(2*f), rounded down, 32-bit.
//   - beat_num wraps only under the loop option; no other counter wraps.
//  Reset mid-operation: immediate return to reset values. rec_len is cleared, so stored notes are lost.
// CONFIGURATION
//  PLAYER_LOOP_EN
//   - Defined: the final playback beat_tick sets beat_num=0 and PLAY continues until stop.
//   - Undefined: the final playback beat_tick returns to IDLE and beat_num holds its last value.
// STRUCTURE
//  Package player_pkg:
//   - KEY_W=6, NUM_NOTES=48, frequency table f[1..48] (equal temperament, A4=440 Hz at code 10).
//   - half_period(code,clk_hz) function; state encoding; tempo multiplier table {4,6,7,8}.
//  Sub-module tone_gen (one per channel via generate): code in, tone out, restart-on-change counter.
//  Note memory is a single inferred block RAM of width 6*N_CH; top level holds FSM and beat timer.
// TESTING
//  1. reset low mid-PLAY -> all outputs at reset values the same cycle; rec_len=0 after release.
//  2. CLK_HZ=100M, IDLE, key_code ch0=10 -> tone_out[0] toggles every 113636 cycles;
//     code 0 -> low within 1 cycle.
//  3. BEAT_BASE=10, speed=0, REC 3 beats of codes 1,5,10, then stop
//     -> rec_len=3, beat_tick period 40 cycles.
//  4. PLAY after test 3 -> channel codes follow 1,5,10 at 40-cycle spacing, then state=IDLE
//     (loop undefined) or beat_num wraps to 0 (PLAYER_LOOP_EN).
//  5. start+stop same cycle, mode_play with rec_len=0, mode_rec&mode_play -> state stays IDLE.
//  6. DEPTH=4 record without stop -> auto IDLE after 4th beat_tick, rec_len=4;
//     speed change mid-REC applies from the next beat.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg: shared constants, state encoding, tempo table and note half-period math
//   KEY_W        width of one channel's note code
//   NUM_NOTES    highest valid note code (1..48 = C4..B7)
//   state_t      FSM encoding as seen on the state output
//   TEMPO_MULT   beat-period multiplier per speed setting
//   note_freq    equal-tempered frequency of a code, A4 = 440 Hz at code 10
//   half_period  clk cycles per half wave of a code, rounded down; 0 for rest codes
package player_pkg;
    localparam int KEY_W = 6;
    localparam int NUM_NOTES = 48;
    typedef enum logic [1:0] {IDLE = 2'b00, REC = 2'b01, PLAY = 2'b10} state_t;
    localparam int TEMPO_MULT [4] = '{4, 6, 7, 8};
    function automatic real note_freq(input int code);
        return 440.0 * 2.0 ** (real'(code - 10) / 12.0);
    endfunction
    function automatic logic [31:0] half_period(input int code, input int clk_hz);
        if (code < 1 || code > NUM_NOTES) return 32'd0;
        return 32'($rtoi(real'(clk_hz) / (2.0 * note_freq(code))));
    endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator for one channel
//   clk, reset (async, active-low)
//   code  note code in; 0 or >NUM_NOTES is a rest
//   tone  square wave out; toggles every half_period(code) cycles, low on rest
module tone_gen
    import player_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] code,
    output logic             tone
);
    logic [31:0] half_tab [2**KEY_W];
    logic [KEY_W-1:0] cur, code_q;
    logic [31:0] cnt;
    // Table is built from constants at elaboration; no runtime real arithmetic.
    for (genvar i = 0; i < 2**KEY_W; i++) begin : g_tab
        assign half_tab[i] = half_period(i, CLK_HZ);
    end
    assign cur = code > KEY_W'(NUM_NOTES) ? '0 : code;
    // A new code restarts the half-period count from a low level.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            code_q <= '0;
            cnt    <= '0;
            tone   <= 1'b0;
        end else if (cur != code_q) begin
            code_q <= cur;
            cnt    <= '0;
            tone   <= 1'b0;
        end else if (code_q != '0) begin
            cnt  <= cnt == half_tab[code_q] - 32'd1 ? '0 : cnt + 32'd1;
            tone <= cnt == half_tab[code_q] - 32'd1 ? ~tone : tone;
        end
endmodule

// File: rtl/poly_tone_player.sv
// poly_tone_player: N-channel square-wave player with beat-quantised record/playback memory
//   clk, reset (async, active-low)
//   key_code   live note per channel (KEY_W bits each)
//   mode_rec, mode_play, start, stop, speed   operation control and tempo
//   tone_out   square wave per channel
//   beat_tick  one-cycle pulse per beat; beat_num current memory address; rec_len beats stored
//   state      00 IDLE, 01 REC, 10 PLAY
// Build option: define PLAYER_LOOP_EN to loop playback until stop instead of ending at rec_len.
module poly_tone_player
    import player_pkg::*;
#(
    parameter  int N_CH      = 2,
    parameter  int DEPTH     = 512,
    parameter  int CLK_HZ    = 100_000_000,
    parameter  int BEAT_BASE = 3_125_000,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_W*N_CH-1:0] key_code,
    input  logic                  mode_rec,
    input  logic                  mode_play,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            speed,
    output logic [N_CH-1:0]       tone_out,
    output logic                  beat_tick,
    output logic [AW-1:0]         beat_num,
    output logic [AW:0]           rec_len,
    output logic [1:0]            state
);
    localparam int CW = KEY_W * N_CH;
    state_t st, st_nx;
    logic [AW-1:0] bn_nx;
    logic [AW:0] len_nx;
    logic [31:0] cnt, period;
    logic [1:0] spd;
    logic [CW-1:0] mem [DEPTH];
    logic [CW-1:0] rd, src;
    logic pv, rest, acc_rec, acc_play, wr, last_rec, last_play;
    assign period    = 32'(BEAT_BASE * TEMPO_MULT[spd]);
    assign beat_tick = cnt == period - 32'd1;
    assign acc_rec   = st == IDLE && start && !stop && mode_rec && !mode_play;
    assign acc_play  = st == IDLE && start && !stop && mode_play && !mode_rec && rec_len != '0;
    assign wr        = st == REC && beat_tick && !stop;
    assign last_rec  = beat_num == AW'(DEPTH - 1);
    assign last_play = beat_num == AW'(rec_len - 1'b1);
    assign state     = st;
    // Speed is latched only on a beat boundary so a beat never changes length midway.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt <= '0;
            spd <= '0;
        end else begin
            cnt <= beat_tick || acc_rec || acc_play ? '0 : cnt + 32'd1;
            spd <= beat_tick ? speed : spd;
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            st       <= IDLE;
            beat_num <= '0;
            rec_len  <= '0;
            pv       <= 1'b0;
            rest     <= 1'b0;
        end else begin
            st       <= st_nx;
            beat_num <= bn_nx;
            rec_len  <= len_nx;
            pv       <= st == PLAY;
            rest     <= st == PLAY && st_nx != PLAY;
        end
    // stop outranks start and beat events; a full memory ends recording on its last write.
    always_comb begin
        st_nx  = st;
        bn_nx  = beat_num;
        len_nx = rec_len;
        if (acc_rec) begin
            st_nx  = REC;
            bn_nx  = '0;
            len_nx = '0;
        end else if (acc_play) begin
            st_nx = PLAY;
            bn_nx = '0;
        end else if (stop && st != IDLE) begin
            st_nx = IDLE;
        end else if (wr) begin
            len_nx = rec_len + 1'b1;
            bn_nx  = last_rec ? beat_num : beat_num + 1'b1;
            st_nx  = last_rec ? IDLE : REC;
        end else if (st == PLAY && beat_tick) begin
`ifdef PLAYER_LOOP_EN
            bn_nx = last_play ? '0 : beat_num + 1'b1;
`else
            bn_nx = last_play ? beat_num : beat_num + 1'b1;
            st_nx = last_play ? IDLE : PLAY;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[beat_num] <= key_code;
        rd <= mem[beat_num];
    end
    // The first PLAY cycle has no valid read yet and the cycle after PLAY is a forced rest.
    assign src = st == PLAY ? (pv ? rd : '0) : (rest ? '0 : key_code);
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        tone_gen #(.CLK_HZ(CLK_HZ)) u_tone (
            .clk  (clk),
            .reset(reset),
            .code (src[c*KEY_W +: KEY_W]),
            .tone (tone_out[c])
        );
    end
endmodule

// File: tb/tb_poly_tone_player.sv
// tb_poly_tone_player: randomized and directed checks of poly_tone_player against a cycle-level reference model
module tb_poly_tone_player;
    localparam int N_CH = 2, DEPTH = 4, CLK_HZ = 20000, BB = 10, AW = 2;
    logic clk = 1'b0, reset = 1'b0;
    logic [11:0] key_code = '0;
    logic mode_rec = 1'b0, mode_play = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0] speed = '0;
    logic [1:0] tone_out;
    logic beat_tick;
    logic [AW-1:0] beat_num;
    logic [AW:0] rec_len;
    logic [1:0] state;

    poly_tone_player #(.N_CH(N_CH), .DEPTH(DEPTH), .CLK_HZ(CLK_HZ), .BEAT_BASE(BB)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .mode_rec(mode_rec), .mode_play(mode_play),
        .start(start), .stop(stop), .speed(speed), .tone_out(tone_out), .beat_tick(beat_tick),
        .beat_num(beat_num), .rec_len(rec_len), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    int cyc, tick_at, m_spd, m_st, m_bn, m_len, p_st, p_bn;
    logic [11:0] m_mem [DEPTH];
    int last [N_CH];
    int since [N_CH];
    int tick_q [$];
    int tog_q [$];
    logic prev_t0;

    function automatic int hp(int c, int hz);
        if (c < 1 || c > 48) return 0;
        return $rtoi($floor(real'(hz) / (2.0 * 440.0 * 2.0 ** (real'(c - 10) / 12.0))));
    endfunction

    function automatic int mult(int s);
        return s == 0 ? 4 : s == 1 ? 6 : s == 2 ? 7 : 8;
    endfunction

    task automatic model_reset();
        cyc = 0; tick_at = 4 * BB - 1; m_spd = 0;
        m_st = 0; m_bn = 0; m_len = 0; p_st = 0; p_bn = 0;
        for (int ch = 0; ch < N_CH; ch++) begin last[ch] = 0; since[ch] = 0; end
    endtask

    // One clock edge of the reference: channels see the note source of the ending cycle.
    task automatic model_step();
        logic [11:0] src;
        bit tick, acc;
        int c;
        if (!reset) begin model_reset(); return; end
        tick = cyc == tick_at;
        src = m_st == 2 ? (p_st == 2 ? m_mem[p_bn] : 12'd0) : (p_st == 2 ? 12'd0 : key_code);
        for (int ch = 0; ch < N_CH; ch++) begin
            c = int'(src[6*ch +: 6]);
            if (c > 48) c = 0;
            if (c != last[ch]) begin last[ch] = c; since[ch] = 0; end
            else since[ch]++;
        end
        p_st = m_st; p_bn = m_bn;
        acc = 0;
        if (m_st == 0) begin
            if (start && !stop && mode_rec && !mode_play) begin
                m_st = 1; m_bn = 0; m_len = 0; acc = 1;
            end else if (start && !stop && mode_play && !mode_rec && m_len != 0) begin
                m_st = 2; m_bn = 0; acc = 1;
            end
        end else if (stop) begin
            m_st = 0;
        end else if (tick && m_st == 1) begin
            m_mem[m_bn] = key_code;
            m_len++;
            if (m_bn == DEPTH - 1) m_st = 0; else m_bn++;
        end else if (tick && m_st == 2) begin
            if (m_bn == m_len - 1) begin
`ifdef PLAYER_LOOP_EN
                m_bn = 0;
`else
                m_st = 0;
`endif
            end else m_bn++;
        end
        if (tick) m_spd = int'(speed);
        if (tick || acc) tick_at = cyc + mult(m_spd) * BB;
        cyc++;
    endtask

    task automatic compare();
        logic [1:0] et;
        logic ek;
        for (int ch = 0; ch < N_CH; ch++)
            et[ch] = last[ch] != 0 && (since[ch] / hp(last[ch], CLK_HZ)) % 2 == 1;
        ek = cyc == tick_at;
        n_vec++;
        if (tone_out !== et || beat_tick !== ek || int'(state) != m_st || int'(beat_num) != m_bn || int'(rec_len) != m_len) begin
            n_bad++;
            $display("FAIL cycle %0d: tone %b want %b, tick %b want %b, state %0d want %0d, beat_num %0d want %0d, rec_len %0d want %0d",
                     cyc, tone_out, et, beat_tick, ek, state, m_st, beat_num, m_bn, rec_len, m_len);
        end
        if (beat_tick) tick_q.push_back(cyc);
        if (tone_out[0] !== prev_t0) tog_q.push_back(cyc);
        prev_t0 = tone_out[0];
    endtask

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_tick(string name);
        for (int i = 0; i < 200; i++) begin
            if (beat_tick) return;
            step();
        end
        check({name, " tick timeout"}, 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        prev_t0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tone_out", int'(tone_out), 0);
        check("reset beat_tick", int'(beat_tick), 0);
        check("reset state", int'(state), 0);
        check("reset rec_len", int'(rec_len), 0);
        check("half 100MHz A4", hp(10, 100_000_000), 113636);
        check("half 20kHz A4", hp(10, CLK_HZ), 22);
        check("half 20kHz C4", hp(1, CLK_HZ), 38);
        check("half 20kHz B7", hp(48, CLK_HZ), 2);
        reset = 1'b1;

        // live tone in IDLE
        key_code = 12'd10;
        tog_q.delete();
        repeat (80) step();
        if (tog_q.size() >= 3) check("A4 toggle spacing", tog_q[2] - tog_q[1], 22);
        else check("A4 toggle count", tog_q.size(), 3);
        for (int i = 0; i < 60 && tone_out[0] !== 1'b1; i++) step();
        check("A4 high before rest", int'(tone_out[0]), 1);
        key_code = 12'd0;
        step();
        check("rest forces low", int'(tone_out[0]), 0);

        // record 3 beats then stop
        key_code = {6'd48, 6'd1};
        mode_rec = 1'b1;
        pulse_start();
        mode_rec = 1'b0;
        check("rec entered", int'(state), 1);
        tick_q.delete();
        wait_tick("rec1"); step();
        key_code = {6'd0, 6'd5};
        wait_tick("rec2"); step();
        key_code = {6'd20, 6'd10};
        wait_tick("rec3"); step();
        stop = 1'b1; step(); stop = 1'b0;
        check("rec_len after stop", int'(rec_len), 3);
        check("idle after stop", int'(state), 0);
        if (tick_q.size() >= 3) begin
            check("rec beat spacing 1", tick_q[1] - tick_q[0], 40);
            check("rec beat spacing 2", tick_q[2] - tick_q[1], 40);
        end else check("rec tick count", tick_q.size(), 3);

        // play back the 3 beats
        key_code = {6'd7, 6'd3};
        mode_play = 1'b1;
        pulse_start();
        mode_play = 1'b0;
        check("play entered", int'(state), 2);
        wait_tick("play1"); check("play beat 0", int'(beat_num), 0); step();
        wait_tick("play2"); check("play beat 1", int'(beat_num), 1); step();
        wait_tick("play3"); check("play beat 2", int'(beat_num), 2); step();
`ifdef PLAYER_LOOP_EN
        check("loop stays in play", int'(state), 2);
        check("loop wraps beat_num", int'(beat_num), 0);
        repeat (30) step();
        stop = 1'b1; step(); stop = 1'b0;
        check("loop stopped", int'(state), 0);
`else
        check("play ends", int'(state), 0);
        check("play end beat_num", int'(beat_num), 2);
`endif
        repeat (5) step();

        // ignored starts
        mode_rec = 1'b1; start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0;
        check("start+stop ignored", int'(state), 0);
        mode_play = 1'b1; pulse_start();
        check("both modes ignored", int'(state), 0);
        mode_rec = 1'b0; mode_play = 1'b0;

        // full-memory record with tempo change
        mode_rec = 1'b1; pulse_start(); mode_rec = 1'b0;
        tick_q.delete();
        wait_tick("full1"); step();
        speed = 2'd3;
        key_code = {6'd30, 6'd12};
        wait_tick("full2"); step();
        key_code = {6'd2, 6'd60};
        wait_tick("full3"); step();
        wait_tick("full4"); step();
        check("auto idle when full", int'(state), 0);
        check("rec_len full", int'(rec_len), 4);
        if (tick_q.size() >= 3) begin
            check("old speed until boundary", tick_q[1] - tick_q[0], 40);
            check("new speed after boundary", tick_q[2] - tick_q[1], 80);
        end else check("full tick count", tick_q.size(), 3);
        speed = 2'd0;

        // reset mid-PLAY
        mode_play = 1'b1; pulse_start(); mode_play = 1'b0;
        repeat (50) step();
        check("playing before reset", int'(state), 2);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async reset tone_out", int'(tone_out), 0);
        check("async reset beat_tick", int'(beat_tick), 0);
        check("async reset beat_num", int'(beat_num), 0);
        check("async reset rec_len", int'(rec_len), 0);
        check("async reset state", int'(state), 0);
        @(negedge clk);
        reset = 1'b1;
        prev_t0 = tone_out[0];
        step();
        check("rec_len lost", int'(rec_len), 0);
        mode_play = 1'b1; pulse_start(); mode_play = 1'b0;
        check("play with empty memory ignored", int'(state), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) key_code = {6'($urandom_range(0, 52)), 6'($urandom_range(0, 52))};
            start = $urandom_range(0, 19) == 0;
            stop = $urandom_range(0, 249) == 0;
            if ($urandom_range(0, 9) == 0) begin
                mode_rec = 1'($urandom_range(0, 1));
                mode_play = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
            if (i == 2000) begin
                #2 reset = 1'b0;
                model_reset();
                @(negedge clk);
                reset = 1'b1;
                prev_t0 = tone_out[0];
            end
            step();
        end
        start = 1'b0; stop = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
